// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for 2**N requesters with a registered one-hot grant.
// Optional maximum-hold preemption is compiled in when ARB_TIMEOUT_EN is defined.
module rr_arbiter8 #(
  parameter int N        = 3,
  parameter int M        = 2**N,
  parameter int MAX_HOLD = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [M-1:0] req,
  output logic [M-1:0] gnt,
  output logic [N-1:0] gnt_idx,
  output logic         gnt_valid,
  output logic         timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_t;

  state_t       state;
  logic [N-1:0] ptr;
  logic [N-1:0] pick_idx;
  logic         pick_ok;

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_hold_range
    $error("rr_arbiter8: MAX_HOLD must lie in 2..255");
  end

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0] hold;
`endif

  // Walk offsets from highest to lowest so the lowest offset from p wins.
  function automatic logic [N:0] rr_pick(input logic [M-1:0] r, input logic [N-1:0] p);
    logic [N-1:0] c;
    logic [N:0]   res;
    res = '0;
    for (int i = M - 1; i >= 0; i--) begin
      c = p + N'(i);
      if (r[c]) res = {1'b1, c};
    end
    return res;
  endfunction

  function automatic logic [M-1:0] onehot(input logic [N-1:0] idx);
    logic [M-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  assign {pick_ok, pick_idx} = rr_pick(req, ptr);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
      ptr       <= '0;
`ifdef ARB_TIMEOUT_EN
      hold      <= '0;
`endif
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE, TURN: begin
          if (!en && pick_ok) begin
            gnt_idx   <= pick_idx;
            gnt       <= onehot(pick_idx);
            gnt_valid <= 1'b1;
            state     <= GRANT;
`ifdef ARB_TIMEOUT_EN
            hold      <= '0;
`endif
          end else begin
            gnt       <= '0;
            gnt_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        GRANT: begin
`ifdef ARB_TIMEOUT_EN
          if (hold != HOLD_LAST) hold <= hold + 8'd1;
`endif
          if (!req[gnt_idx]) begin
            gnt       <= '0;
            gnt_valid <= 1'b0;
            ptr       <= gnt_idx + N'(1);
            state     <= TURN;
          end
`ifdef ARB_TIMEOUT_EN
          else if (hold == HOLD_LAST) begin
            // Owner still requesting but out of time: force a handover.
            gnt       <= '0;
            gnt_valid <= 1'b0;
            ptr       <= gnt_idx + N'(1);
            timeout   <= 1'b1;
            state     <= TURN;
          end
`endif
        end
        default: begin
          gnt       <= '0;
          gnt_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed self-checking bench for rr_arbiter8 (MAX_HOLD = 4).
// Preemption steps are compiled only when ARB_TIMEOUT_EN is defined.
module tb_rr_arbiter8;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int errors = 0;
  int checks = 0;

  rr_arbiter8 #(.N(3), .MAX_HOLD(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_gnt(input string tag, input logic [7:0] eg, input logic [2:0] ei);
    check({tag, ".gnt"}, 32'(gnt), 32'(eg));
    check({tag, ".idx"}, 32'(gnt_idx), 32'(ei));
    check({tag, ".valid"}, 32'(gnt_valid), 32'(eg != 8'h00));
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; req = 8'h00;
    step(); step();
    check_gnt("reset", 8'h00, 3'd0);
    check("reset.timeout", 32'(timeout), 32'd0);
    rst = 1'b0;
    step();
    check_gnt("idle", 8'h00, 3'd0);

    // Single request: grant one edge later, release one edge after drop.
    req = 8'h04; step();
    check_gnt("single.grant", 8'h04, 3'd2);
    req = 8'h00; step();
    check_gnt("single.release", 8'h00, 3'd2);
    step();                                   // ptr = 3

    // Owner 6 leaves ptr at 7; then 7 beats 0, and 0 follows after wrap.
    req = 8'h40; step();
    check_gnt("own6", 8'h40, 3'd6);
    req = 8'h00; step();
    check_gnt("own6.rel", 8'h00, 3'd6);
    req = 8'h81; step();
    check_gnt("wrap.first7", 8'h80, 3'd7);
    req = 8'h01; step();
    check_gnt("wrap.rel7", 8'h00, 3'd7);
    step();
    check_gnt("wrap.then0", 8'h01, 3'd0);
    req = 8'h00; step();
    check_gnt("wrap.rel0", 8'h00, 3'd0);      // ptr = 1
    step();

    // Back-to-back: owner 1, a dead cycle, then owner 2; non-owner waits.
    req = 8'h06; step();
    check_gnt("b2b.own1", 8'h02, 3'd1);
    step();
    check_gnt("b2b.hold1", 8'h02, 3'd1);
    req = 8'h04; step();
    check_gnt("b2b.dead", 8'h00, 3'd1);
    step();
    check_gnt("b2b.own2", 8'h04, 3'd2);
    req = 8'h00; step();
    check_gnt("b2b.rel2", 8'h00, 3'd2);       // ptr = 3
    step();

    // Enable blocks new grants only.
    en = 1'b1; req = 8'h10; step();
    check_gnt("en.block1", 8'h00, 3'd2);
    step();
    check_gnt("en.block2", 8'h00, 3'd2);
    en = 1'b0; step();
    check_gnt("en.grant", 8'h10, 3'd4);
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_gnt("en.midgrant", 8'h10, 3'd4);
    end
    req = 8'h00; step();
    check_gnt("en.rel", 8'h00, 3'd4);         // ptr = 5
    en = 1'b0; step();

    // Reset in the middle of a grant.
    req = 8'h20; step();
    check_gnt("rst.own5", 8'h20, 3'd5);
    rst = 1'b1; step();
    check_gnt("rst.mid", 8'h00, 3'd0);
    check("rst.timeout", 32'(timeout), 32'd0);
    rst = 1'b0; req = 8'h60; step();
    check_gnt("rst.regrant5", 8'h20, 3'd5);
    req = 8'h00; step();                      // ptr = 6
    check_gnt("rst.rel5", 8'h00, 3'd5);
    rst = 1'b1; step();
    rst = 1'b0; req = 8'h41; step();
    check_gnt("rst.ptrclear", 8'h01, 3'd0);
    req = 8'h00; step(); step();

`ifdef ARB_TIMEOUT_EN
    // All requesting: 4-cycle grants rotating 0..7,0 with timeout on each dead cycle.
    rst = 1'b1; step();
    rst = 1'b0; req = 8'hFF;
    for (int o = 0; o < 9; o++) begin
      for (int c = 0; c < 4; c++) begin
        step();
        check_gnt("rot.grant", 8'h01 << (o % 8), 3'(o % 8));
        check("rot.notimeout", 32'(timeout), 32'd0);
      end
      step();
      check_gnt("rot.dead", 8'h00, 3'(o % 8));
      check("rot.timeout", 32'(timeout), 32'd1);
    end
    req = 8'h00; step(); step();
`else
    // No preemption: owner 3 keeps the resource while others wait.
    rst = 1'b1; step();
    rst = 1'b0; req = 8'h08; step();
    check_gnt("hold.start", 8'h08, 3'd3);
    req = 8'hFF;
    for (int c = 0; c < 40; c++) begin
      step();
      check_gnt("hold.keep", 8'h08, 3'd3);
      check("hold.notimeout", 32'(timeout), 32'd0);
    end
    req = 8'hF7; step();
    check_gnt("hold.rel", 8'h00, 3'd3);
    step();
    check_gnt("hold.next4", 8'h10, 3'd4);
    req = 8'h00; step(); step();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rr_arbiter8.md
# rr_arbiter8

Round-robin arbiter that shares one downstream resource among 2**N requesters (8 by default). It registers a granted index, drives a one-hot grant vector (the decoded index, all-zero when idle) and enforces an optional maximum hold time. It sits between the requesting units and the shared resource, and its grant vector selects which requester owns the resource.

## Interface
- N, 3, index width; requester count M = 2**N
- M, 2**N, number of requesters (derived; not overridden)
- MAX_HOLD, 16, maximum consecutive grant cycles per owner (legal range 2..255)
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- en  input  1  active-low arbitration enable: 0 = arbitrate, 1 = no new grants
- req  input  M  request vector; bit i is held high by requester i while it wants or uses the resource
- gnt  output  M  one-hot grant; all-zero when nobody owns the resource
- gnt_idx  output  N  index of current owner; holds the last owner when gnt is zero
- gnt_valid  output  1  high when gnt is non-zero
- timeout  output  1  one-cycle pulse when an owner is preempted by MAX_HOLD

## Operation
- States: IDLE, GRANT, TURN. Reset state is IDLE.
- Reset values:
  - gnt = 0, gnt_idx = 0, gnt_valid = 0, timeout = 0.
  - Internal round-robin pointer ptr = 0 and hold counter = 0.
- IDLE and TURN (arbitration states):
  - If en = 0 and req != 0, select the first set bit of req searching upward from ptr with wrap-around (ptr, ptr+1, ..., M-1, 0, ..., ptr-1).
  - Load that index into gnt_idx, set gnt = decode(gnt_idx), gnt_valid = 1, clear the hold counter, and go to GRANT.
  - Otherwise go to, or stay in, IDLE with gnt = 0.
- GRANT:
  - The hold counter increments each cycle.
  - Release: if req[gnt_idx] = 0, set gnt = 0 and ptr = gnt_idx+1 (mod M), then go to TURN.
  - Preemption (macro only): if req[gnt_idx] = 1 and the counter equals MAX_HOLD-1, set gnt = 0, ptr = gnt_idx+1 (mod M), pulse timeout for one cycle, and go to TURN.
  - Otherwise hold the grant.
- TURN always lasts exactly one cycle with gnt = 0, and arbitration happens in that same cycle. The resource is therefore never handed from one owner to the next without a dead cycle.
- en = 1 only blocks arbitration in IDLE/TURN. A grant already in progress proceeds and releases normally.
- Requests from non-owners during GRANT are ignored until the next arbitration.
- ptr wrap: the value M-1 followed by +1 gives 0. The pointer width is exactly N bits, so wrap is natural overflow.
- The hold counter is 8 bits unsigned and saturates at MAX_HOLD-1. It is cleared on every new grant.
- gnt is always zero or one-hot. It never holds two or more bits.
- rst asserted in any state, including mid-grant, returns to IDLE with the reset values on the next edge. The pre-reset owner is not remembered.

## Timing
- Grant latency: with req rising at edge k (sampled at edge k) in IDLE and en = 0, gnt is high after edge k. Registered outputs only; there is no combinational path from req to gnt.
- Release latency: req[owner] falling and sampled at edge k gives gnt = 0 after edge k. The earliest next grant appears after edge k+1.
- Minimum grant length is 1 cycle.
- Maximum grant length is MAX_HOLD cycles when ARB_TIMEOUT_EN is defined.
- timeout is high for exactly the TURN cycle that follows a preemption.
- Back-to-back service of two requesters: owner A, one dead cycle, owner B.

## Configuration
- ARB_TIMEOUT_EN defined:
  - MAX_HOLD preemption is active.
  - timeout pulses as described under Operation.
- ARB_TIMEOUT_EN undefined:
  - No preemption; an owner keeps the grant until req[owner] drops.
  - timeout is tied to 0.
  - The hold counter is removed.
  - The MAX_HOLD parameter is ignored.

## Test plan
- Reset, then req = 8'b0000_0100, en = 0 → gnt = 8'b0000_0100 and gnt_idx = 2 one cycle later; drop req[2] → gnt = 0 next cycle.
- req = 8'hFF held, ARB_TIMEOUT_EN, MAX_HOLD = 4 → grants rotate 0, 1, 2, ..., 7, 0, each 4 cycles long separated by one zero cycle, with timeout pulsing at each handover.
- ptr = 7 after owner 6 releases, req = 8'b1000_0001 → owner 7 is granted before owner 0; after 7 releases, owner 0 is granted (wrap).
- en = 1 while req = 8'h10 in IDLE → gnt stays 0; en falls to 0 → gnt = 8'h10 on the next edge. Separately, en rises mid-grant → the grant continues until req drops.
- rst asserted mid-grant (gnt_idx = 5) → next edge gives gnt = 0, gnt_idx = 0, timeout = 0; with req = 8'h60 after reset, owner 5 is granted (search from ptr = 0).
- Without ARB_TIMEOUT_EN, req[3] held for 40 cycles with other requests pending → gnt stays 8'h08 for all 40 cycles and timeout never asserts.
